// File: rtl/result_digit_converter_if.sv
// Start/busy/done handshake and BCD result bus between requester and converter.
interface result_digit_converter_if;
    logic        start;
    logic [15:0] value;
    logic        busy;
    logic        done;
    logic [3:0]  digit4;
    logic [3:0]  digit3;
    logic [3:0]  digit2;
    logic [3:0]  digit1;
    logic [3:0]  digit0;
    logic [2:0]  ndigits;
    logic        over999;

    modport master (
        output start, value,
        input  busy, done, digit4, digit3, digit2, digit1, digit0, ndigits, over999
    );

    modport slave (
        input  start, value,
        output busy, done, digit4, digit3, digit2, digit1, digit0, ndigits, over999
    );
endinterface

// File: rtl/result_digit_converter.sv
// Iterative double-dabble binary-to-BCD converter, 16-bit value to five digits.
// Fixed 17-edge latency from accepted start to done; start is ignored while busy.
module result_digit_converter (
    input  logic                         clk,
    input  logic                         reset,
    result_digit_converter_if.slave      bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state, state_nxt;
    logic [35:0] work;
    logic [35:0] work_step;
    logic [19:0] bcd_corr;
    logic [3:0]  cnt;
    logic [3:0]  d4, d3, d2, d1, d0;
    logic [2:0]  nd, nd_calc;
    logic        ov;
    logic        done_r;

    // All five corrections look at the pre-step nibbles, then the whole word shifts.
    always_comb begin
        bcd_corr = '0;
        for (int i = 0; i < 5; i++) begin
            if (work[16 + 4*i +: 4] >= 4'd5)
                bcd_corr[4*i +: 4] = work[16 + 4*i +: 4] + 4'd3;
            else
                bcd_corr[4*i +: 4] = work[16 + 4*i +: 4];
        end
        work_step = {bcd_corr[18:0], work[15:0], 1'b0};
    end

    always_comb begin
        if (work[35:32] != 4'd0)
            nd_calc = 3'd5;
        else if (work[31:28] != 4'd0)
            nd_calc = 3'd4;
        else if (work[27:24] != 4'd0)
            nd_calc = 3'd3;
        else if (work[23:20] != 4'd0)
            nd_calc = 3'd2;
        else
            nd_calc = 3'd1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = SHIFT;
            SHIFT:   if (cnt == 4'd15) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            work   <= '0;
            cnt    <= '0;
            done_r <= 1'b0;
            d4     <= '0;
            d3     <= '0;
            d2     <= '0;
            d1     <= '0;
            d0     <= '0;
            nd     <= 3'd1;
            ov     <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        work <= {20'b0, bus.value};
                        cnt  <= '0;
                    end
                end
                SHIFT: begin
                    work <= work_step;
                    cnt  <= cnt + 4'd1;
                end
                DONE: begin
                    d4     <= work[35:32];
                    d3     <= work[31:28];
                    d2     <= work[27:24];
                    d1     <= work[23:20];
                    d0     <= work[19:16];
                    nd     <= nd_calc;
                    ov     <= (work[35:32] != 4'd0) || (work[31:28] != 4'd0);
                    done_r <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = (state != IDLE);
    assign bus.done    = done_r;
    assign bus.digit4  = d4;
    assign bus.digit3  = d3;
    assign bus.digit2  = d2;
    assign bus.digit1  = d1;
    assign bus.digit0  = d0;
    assign bus.ndigits = nd;
    assign bus.over999 = ov;
endmodule

// File: tb/tb_result_digit_converter.sv
// Directed table, handshake corner sequences and a strided sweep against a decimal model.
module tb_result_digit_converter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    result_digit_converter_if bus();
    result_digit_converter dut (.clk(clk), .reset(reset), .bus(bus.slave));

    int n_checks = 0;
    int n_fail   = 0;
    int nib_err  = 0;

    typedef struct {
        logic [15:0] v;
        logic [3:0]  d4, d3, d2, d1, d0;
        logic [2:0]  nd;
        logic        ov;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] model(input logic [15:0] v);
        int x;
        logic [3:0] d [5];
        logic [2:0] nd;
        x  = int'(v);
        nd = 3'd1;
        for (int i = 0; i < 5; i++) begin
            d[i] = 4'(x % 10);
            x    = x / 10;
            if (d[i] != 4'd0) nd = 3'(i + 1);
        end
        return {d[4], d[3], d[2], d[1], d[0], nd, (d[4] != 4'd0) || (d[3] != 4'd0)};
    endfunction

    function automatic logic [23:0] outs();
        return {bus.digit4, bus.digit3, bus.digit2, bus.digit1, bus.digit0, bus.ndigits, bus.over999};
    endfunction

    // Any BCD nibble above 9 in the work register during a conversion is a datapath error.
    always @(negedge clk) begin
        for (int k = 0; k < 5; k++)
            if (dut.work[16 + 4*k +: 4] > 4'd9) nib_err++;
    end

    // Called at a negedge with the DUT idle; returns at the negedge of the done cycle.
    task automatic run_conv(input logic [15:0] v, input logic [23:0] exp, input bit noise, input string tag);
        int lat;
        int bc;
        lat = 0;
        bc  = 0;
        bus.start = 1'b1;
        bus.value = v;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        if (bus.busy) bc++;
        check({tag, "_done_low_after_accept"}, 32'(bus.done), 32'd0);
        for (int i = 1; i <= 40; i++) begin
            if (noise && i >= 3 && i <= 10) begin
                bus.start = 1'b1;
                bus.value = (i % 2 == 1) ? 16'd7 : 16'hFFFF;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            if (bus.done) begin
                lat = i;
                break;
            end
            if (bus.busy) bc++;
        end
        bus.start = 1'b0;
        check({tag, "_latency"}, 32'(lat), 32'd17);
        check({tag, "_busy_cycles"}, 32'(bc), 32'd17);
        check({tag, "_busy_low_at_done"}, 32'(bus.busy), 32'd0);
        check({tag, "_result"}, 32'(outs()), 32'(exp));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dn;
        tbl[0] = '{16'd0,     4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 3'd1, 1'b0};
        tbl[1] = '{16'd65535, 4'd6, 4'd5, 4'd5, 4'd3, 4'd5, 3'd5, 1'b1};
        tbl[2] = '{16'd999,   4'd0, 4'd0, 4'd9, 4'd9, 4'd9, 3'd3, 1'b0};
        tbl[3] = '{16'd1000,  4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 3'd4, 1'b1};
        tbl[4] = '{16'd9,     4'd0, 4'd0, 4'd0, 4'd0, 4'd9, 3'd1, 1'b0};
        tbl[5] = '{16'd10,    4'd0, 4'd0, 4'd0, 4'd1, 4'd0, 3'd2, 1'b0};
        tbl[6] = '{16'd100,   4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 3'd3, 1'b0};
        tbl[7] = '{16'd10000, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 3'd5, 1'b1};
        tbl[8] = '{16'd59999, 4'd5, 4'd9, 4'd9, 4'd9, 4'd9, 3'd5, 1'b1};
        tbl[9] = '{16'd12345, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 3'd5, 1'b1};

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.value = 16'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 32'(outs()), 32'h000002);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Table entries run back to back: each start is driven in the previous done cycle.
        for (int t = 0; t < 10; t++)
            run_conv(tbl[t].v,
                     {tbl[t].d4, tbl[t].d3, tbl[t].d2, tbl[t].d1, tbl[t].d0, tbl[t].nd, tbl[t].ov},
                     1'b0, $sformatf("tbl%0d", t));

        // Start and value activity while busy must be ignored and not queued.
        run_conv(16'd42, {4'd0, 4'd0, 4'd0, 4'd4, 4'd2, 3'd2, 1'b0}, 1'b1, "ignore_busy");
        dn = 0;
        repeat (25) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done || bus.busy) dn++;
        end
        check("ignore_busy_no_extra_activity", 32'(dn), 32'd0);
        check("ignore_busy_result_held", 32'(outs()), 32'(model(16'd42)));

        // Reset in the middle of a conversion aborts it without a done pulse.
        run_conv(16'd12345, model(16'd12345), 1'b0, "pre_abort");
        bus.start = 1'b1;
        bus.value = 16'd500;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("abort_busy_before_reset", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("abort_outputs_reset", 32'(outs()), 32'h000002);
        check("abort_busy", 32'(bus.busy), 32'd0);
        dn = 0;
        repeat (25) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done) dn++;
        end
        check("abort_no_done", 32'(dn), 32'd0);
        run_conv(16'd500, {4'd0, 4'd0, 4'd5, 4'd0, 4'd0, 3'd3, 1'b0}, 1'b0, "after_abort");

        // Reset and start on the same edge: reset wins.
        reset     = 1'b1;
        bus.start = 1'b1;
        bus.value = 16'd123;
        @(posedge clk);
        @(negedge clk);
        reset     = 1'b0;
        bus.start = 1'b0;
        check("reset_beats_start_busy", 32'(bus.busy), 32'd0);
        check("reset_beats_start_outputs", 32'(outs()), 32'h000002);
        @(posedge clk);
        @(negedge clk);
        check("reset_beats_start_still_idle", 32'(bus.busy), 32'd0);

        for (int v = 0; v < 65536; v += 37)
            run_conv(16'(v), model(16'(v)), 1'b0, $sformatf("sweep_%0d", v));
        run_conv(16'd65534, model(16'd65534), 1'b0, "sweep_65534");

        check("nibble_range_errors", 32'(nib_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
